// File: rtl/sum_window_arb.sv
// Two-channel sliding-window summer sharing one update path through a round-robin arbiter.
// Each channel keeps its own WIN-deep history and running sum. The admitted channel's new sum is registered for output.
module sum_window_arb #(
    parameter int DATA_W = 8,
    parameter int WIN    = 4,
    parameter int SUM_W  = DATA_W + $clog2(WIN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in0,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic              clr0,
    input  logic [DATA_W-1:0] in1,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic              clr1,
    output logic [SUM_W-1:0]  out_sum,
    output logic              out_ch,
    output logic              out_valid
);

    logic [DATA_W-1:0] din [2];
    logic [1:0]        clr;
    logic [1:0]        elig;
    logic [1:0]        grant;

    logic [DATA_W-1:0] hist_q [2][WIN];
    logic [DATA_W-1:0] hist_d [2][WIN];
    logic [SUM_W-1:0]  sum_q  [2];
    logic [SUM_W-1:0]  sum_d  [2];
    logic              last_grant_q, last_grant_d;
    logic [SUM_W-1:0]  out_sum_q, out_sum_d;
    logic              out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;

    assign din[0] = in0;
    assign din[1] = in1;
    assign clr    = {clr1, clr0};
    assign elig   = {in1_valid & ~clr1, in0_valid & ~clr0};

    // A clearing channel is never eligible, so clear always wins over a transfer.
    always_comb begin
        grant = 2'b00;
        case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign in0_ready = grant[0];
    assign in1_ready = grant[1];

    // Sums are updated incrementally: add the newcomer, drop the oldest sample.
    always_comb begin
        hist_d       = hist_q;
        sum_d        = sum_q;
        last_grant_d = last_grant_q;
        out_sum_d    = out_sum_q;
        out_ch_d     = out_ch_q;
        out_valid_d  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (clr[c]) begin
                for (int i = 0; i < WIN; i++) begin
                    hist_d[c][i] = '0;
                end
                sum_d[c] = '0;
            end else if (grant[c]) begin
                for (int i = WIN - 1; i > 0; i--) begin
                    hist_d[c][i] = hist_q[c][i-1];
                end
                hist_d[c][0] = din[c];
                sum_d[c] = sum_q[c] + SUM_W'(din[c]) - SUM_W'(hist_q[c][WIN-1]);
            end
        end
        if (grant != 2'b00) begin
            last_grant_d = grant[1];
            out_ch_d     = grant[1];
            out_sum_d    = grant[1] ? sum_d[1] : sum_d[0];
            out_valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < WIN; i++) begin
                    hist_q[c][i] <= '0;
                end
                sum_q[c] <= '0;
            end
            last_grant_q <= 1'b1;
            out_sum_q    <= '0;
            out_ch_q     <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            sum_q        <= sum_d;
            last_grant_q <= last_grant_d;
            out_sum_q    <= out_sum_d;
            out_ch_q     <= out_ch_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_sum   = out_sum_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sum_window_arb.sv
// Directed self-checking bench for sum_window_arb with hand-computed sums and grants.
// Inputs change on the falling edge; readys are checked before the rising edge and outputs 1 time unit after it.
module tb_sum_window_arb;

    logic       clk;
    logic       reset;
    logic [7:0] in0;
    logic       in0_valid;
    logic       in0_ready;
    logic       clr0;
    logic [7:0] in1;
    logic       in1_valid;
    logic       in1_ready;
    logic       clr1;
    logic [9:0] out_sum;
    logic       out_ch;
    logic       out_valid;

    int totalCount;
    int badCount;

    sum_window_arb dut (
        .clk       (clk),
        .reset     (reset),
        .in0       (in0),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .clr0      (clr0),
        .in1       (in1),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .clr1      (clr1),
        .out_sum   (out_sum),
        .out_ch    (out_ch),
        .out_valid (out_valid)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when the observed value is not the expected one
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, checks readys before the edge and outputs after it
    task automatic applyStimulus(
        input string      tag,
        input logic       v0, input logic [7:0] d0, input logic c0,
        input logic       v1, input logic [7:0] d1, input logic c1,
        input logic       expR0, input logic expR1,
        input logic       expOv, input logic expCh, input logic [9:0] expSum
    );
        @(negedge clk);
        in0_valid = v0; in0 = d0; clr0 = c0;
        in1_valid = v1; in1 = d1; clr1 = c1;
        #1;
        checkOutput({tag, ".ready0"}, 32'(in0_ready), 32'(expR0));
        checkOutput({tag, ".ready1"}, 32'(in1_ready), 32'(expR1));
        @(posedge clk);
        #1;
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(expOv));
        checkOutput({tag, ".out_ch"}, 32'(out_ch), 32'(expCh));
        checkOutput({tag, ".out_sum"}, 32'(out_sum), 32'(expSum));
    endtask

    // Pulses reset low across one rising edge and leaves inputs idle
    task automatic doReset();
        @(negedge clk);
        in0_valid = 1'b0; in1_valid = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        in0 = '0; in1 = '0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        totalCount = 0;
        badCount   = 0;
        reset = 1'b0;
        in0 = '0; in0_valid = 1'b0; clr0 = 1'b0;
        in1 = '0; in1_valid = 1'b0; clr1 = 1'b0;
        #12;
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.out_sum", 32'(out_sum), 32'd0);
        checkOutput("reset.out_ch", 32'(out_ch), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] test 1: channel 0 partial and full windows");
        applyStimulus("t1a", 1, 100, 0, 0, 0, 0, 1, 0, 1, 0, 100);
        applyStimulus("t1b", 1, 100, 0, 0, 0, 0, 1, 0, 1, 0, 200);
        applyStimulus("t1c", 1,   0, 0, 0, 0, 0, 1, 0, 1, 0, 200);
        applyStimulus("t1d", 1,  50, 0, 0, 0, 0, 1, 0, 1, 0, 250);
        applyStimulus("t1e", 1,  50, 0, 0, 0, 0, 1, 0, 1, 0, 200);
        applyStimulus("t1f", 1, 250, 0, 0, 0, 0, 1, 0, 1, 0, 350);

        $display("[TB] test 2: clear then maximum sum without wrap");
        applyStimulus("t2clr", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 350);
        applyStimulus("t2a", 1, 255, 0, 0, 0, 0, 1, 0, 1, 0, 255);
        applyStimulus("t2b", 1, 255, 0, 0, 0, 0, 1, 0, 1, 0, 510);
        applyStimulus("t2c", 1, 255, 0, 0, 0, 0, 1, 0, 1, 0, 765);
        applyStimulus("t2d", 1, 255, 0, 0, 0, 0, 1, 0, 1, 0, 1020);
        applyStimulus("t2e", 1,   0, 0, 0, 0, 0, 1, 0, 1, 0, 765);
        applyStimulus("t2f", 1,   0, 0, 0, 0, 0, 1, 0, 1, 0, 510);
        applyStimulus("t2g", 1,   0, 0, 0, 0, 0, 1, 0, 1, 0, 255);
        applyStimulus("t2h", 1,   0, 0, 0, 0, 0, 1, 0, 1, 0, 0);

        $display("[TB] test 3: round-robin alternation");
        doReset();
        applyStimulus("t3a", 1, 10, 0, 1, 20, 0, 1, 0, 1, 0, 10);
        applyStimulus("t3b", 1, 11, 0, 1, 20, 0, 0, 1, 1, 1, 20);
        applyStimulus("t3c", 1, 11, 0, 1, 21, 0, 1, 0, 1, 0, 21);
        applyStimulus("t3d", 1, 12, 0, 1, 21, 0, 0, 1, 1, 1, 41);
        applyStimulus("t3e", 1, 12, 0, 1, 22, 0, 1, 0, 1, 0, 33);
        applyStimulus("t3f", 0,  0, 0, 1, 22, 0, 0, 1, 1, 1, 63);

        $display("[TB] test 4: clear beats transfer, other channel proceeds");
        doReset();
        applyStimulus("t4a", 1, 10, 0, 0, 0, 0, 1, 0, 1, 0, 10);
        applyStimulus("t4b", 1, 11, 0, 0, 0, 0, 1, 0, 1, 0, 21);
        applyStimulus("t4c", 1, 12, 0, 0, 0, 0, 1, 0, 1, 0, 33);
        applyStimulus("t4clr", 1, 13, 1, 1, 5, 0, 0, 1, 1, 1, 5);
        applyStimulus("t4d", 1, 20, 0, 0, 0, 0, 1, 0, 1, 0, 20);

        $display("[TB] test 5: mid-stream reset");
        doReset();
        applyStimulus("t5a", 1, 100, 0, 0, 0, 0, 1, 0, 1, 0, 100);
        applyStimulus("t5b", 1, 100, 0, 0, 0, 0, 1, 0, 1, 0, 200);
        reset = 1'b0;
        #1;
        checkOutput("t5rst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("t5rst.out_sum", 32'(out_sum), 32'd0);
        checkOutput("t5rst.out_ch", 32'(out_ch), 32'd0);
        @(negedge clk);
        in0_valid = 1'b0; in1_valid = 1'b0;
        reset = 1'b1;
        applyStimulus("t5c", 1, 50, 0, 1, 7, 0, 1, 0, 1, 0, 50);
        applyStimulus("t5d", 0,  0, 0, 1, 7, 0, 0, 1, 1, 1, 7);

        $display("[TB] test 6: idle cycles hold output");
        applyStimulus("t6a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        applyStimulus("t6b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        applyStimulus("t6c", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
